// File: rtl/sysbus_arb_pkg.sv
// rtl/sysbus_arb_pkg.sv - shared state, owner and tag constants for the SysBus port arbiter
package sysbus_arb_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        ISIDE = 2'd1,
        DSIDE = 2'd2
    } owner_e;

    localparam int DEFAULT_TAG_WIDTH = 13;
    localparam int WRITE_TAG_BIT     = DEFAULT_TAG_WIDTH - 1;

    function automatic int write_tag_bit(input int tag_width);
        return tag_width - 1;
    endfunction

endpackage

// File: rtl/sysbus_port_arbiter_rr_picker2.sv
// rtl/sysbus_port_arbiter_rr_picker2.sv - 2-way round-robin picker, I side wins the first tie
module rr_picker2 (
    input  logic clk,
    input  logic reset,
    input  logic i_cyc,
    input  logic d_cyc,
    input  logic grant_en,
    output logic pick_i,
    output logic pick_d
);

    logic last_d;

    assign pick_i = i_cyc & (~d_cyc | last_d);
    assign pick_d = d_cyc & ~pick_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_d <= 1'b1;
        end else if (grant_en && (pick_i || pick_d)) begin
            last_d <= pick_d;
        end
    end

endmodule

// File: rtl/sysbus_port_arbiter.sv
// rtl/sysbus_port_arbiter.sv - shares one SysBus port between I fetch and D cache, one transaction at a time
module sysbus_port_arbiter
    import sysbus_arb_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int TAG_WIDTH = 13,
    parameter int BEATS     = 8
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic [WIDTH-1:0]     i_req,
    input  logic [TAG_WIDTH-1:0] i_reqtag,
    input  logic [WIDTH-1:0]     i_reqdata,
    input  logic                 i_reqcyc,
    output logic                 i_reqack,
    output logic [WIDTH-1:0]     i_resp,
    output logic [TAG_WIDTH-1:0] i_resptag,
    output logic                 i_respcyc,
    output logic                 i_writeack,

    input  logic [WIDTH-1:0]     d_req,
    input  logic [TAG_WIDTH-1:0] d_reqtag,
    input  logic [WIDTH-1:0]     d_reqdata,
    input  logic                 d_reqcyc,
    output logic                 d_reqack,
    output logic [WIDTH-1:0]     d_resp,
    output logic [TAG_WIDTH-1:0] d_resptag,
    output logic                 d_respcyc,
    output logic                 d_writeack,

    output logic [WIDTH-1:0]     bus_req,
    output logic [TAG_WIDTH-1:0] bus_reqtag,
    output logic [WIDTH-1:0]     bus_reqdata,
    output logic                 bus_reqcyc,
    input  logic                 bus_reqack,
    input  logic [WIDTH-1:0]     bus_resp,
    input  logic [TAG_WIDTH-1:0] bus_resptag,
    input  logic                 bus_respcyc,
    output logic                 bus_respack,
    input  logic                 bus_writeack
);

    localparam int WBIT = write_tag_bit(TAG_WIDTH);
    localparam int CW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    logic [1:0]    state;
    owner_e        owner;
    logic          is_write;
    logic [CW-1:0] beat_cnt;
    logic          pick_i;
    logic          pick_d;

    rr_picker2 u_picker (
        .clk      (clk),
        .reset    (reset),
        .i_cyc    (i_reqcyc),
        .d_cyc    (d_reqcyc),
        .grant_en (state == IDLE),
        .pick_i   (pick_i),
        .pick_d   (pick_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= NONE;
            is_write    <= 1'b0;
            beat_cnt    <= '0;
            i_reqack    <= 1'b0;
            i_resp      <= '0;
            i_resptag   <= '0;
            i_respcyc   <= 1'b0;
            i_writeack  <= 1'b0;
            d_reqack    <= 1'b0;
            d_resp      <= '0;
            d_resptag   <= '0;
            d_respcyc   <= 1'b0;
            d_writeack  <= 1'b0;
            bus_req     <= '0;
            bus_reqtag  <= '0;
            bus_reqdata <= '0;
            bus_reqcyc  <= 1'b0;
            bus_respack <= 1'b0;
        end else begin
            // Every response-side strobe is a single-cycle pulse unless re-asserted below.
            i_reqack    <= 1'b0;
            d_reqack    <= 1'b0;
            i_respcyc   <= 1'b0;
            d_respcyc   <= 1'b0;
            i_writeack  <= 1'b0;
            d_writeack  <= 1'b0;
            bus_respack <= 1'b0;

            case (state)
                IDLE: begin
                    if (pick_i) begin
                        bus_req     <= i_req;
                        bus_reqtag  <= i_reqtag;
                        bus_reqdata <= i_reqdata;
                        bus_reqcyc  <= 1'b1;
                        i_reqack    <= 1'b1;
                        owner       <= ISIDE;
                        is_write    <= i_reqtag[WBIT];
                        beat_cnt    <= '0;
                        state       <= ISSUE;
                    end else if (pick_d) begin
                        bus_req     <= d_req;
                        bus_reqtag  <= d_reqtag;
                        bus_reqdata <= d_reqdata;
                        bus_reqcyc  <= 1'b1;
                        d_reqack    <= 1'b1;
                        owner       <= DSIDE;
                        is_write    <= d_reqtag[WBIT];
                        beat_cnt    <= '0;
                        state       <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (bus_reqack) begin
                        bus_reqcyc <= 1'b0;
                        state      <= WAIT;
                    end
                end

                WAIT: begin
                    if (bus_respcyc) begin
                        bus_respack <= 1'b1;
                    end
                    if (is_write) begin
                        // Stray read beats during a write are acked above and dropped here.
                        if (bus_writeack) begin
                            i_writeack <= (owner == ISIDE);
                            d_writeack <= (owner == DSIDE);
                            owner      <= NONE;
                            state      <= IDLE;
                        end
                    end else if (bus_respcyc) begin
                        if (owner == ISIDE) begin
                            i_resp    <= bus_resp;
                            i_resptag <= bus_resptag;
                            i_respcyc <= 1'b1;
                        end else if (owner == DSIDE) begin
                            d_resp    <= bus_resp;
                            d_resptag <= bus_resptag;
                            d_respcyc <= 1'b1;
                        end
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == LAST_BEAT) begin
                            owner <= NONE;
                            state <= IDLE;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    owner <= NONE;
                end
            endcase
        end
    end

    i_side_write: assert property (@(posedge clk) disable iff (reset)
        !(state == IDLE && pick_i && i_reqtag[WBIT]))
        else $warning("I-side request carries the write tag bit");

endmodule

// File: tb/tb_sysbus_port_arbiter.sv
// tb/tb_sysbus_port_arbiter.sv - scoreboard bench for sysbus_port_arbiter acting as both requesters and SysBus
module tb_sysbus_port_arbiter;

    localparam int WIDTH = 64;
    localparam int TW    = 13;
    localparam int KIND_ACK  = 0;
    localparam int KIND_BEAT = 1;
    localparam int KIND_WACK = 2;

    typedef struct {
        int          kind;
        int          side;
        logic [63:0] data;
        logic [12:0] tag;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic [WIDTH-1:0] i_req, i_reqdata, i_resp, d_req, d_reqdata, d_resp;
    logic [TW-1:0]    i_reqtag, i_resptag, d_reqtag, d_resptag;
    logic i_reqcyc, i_reqack, i_respcyc, i_writeack;
    logic d_reqcyc, d_reqack, d_respcyc, d_writeack;
    logic [WIDTH-1:0] bus_req, bus_reqdata, bus_resp;
    logic [TW-1:0]    bus_reqtag, bus_resptag;
    logic bus_reqcyc, bus_reqack, bus_respcyc, bus_respack, bus_writeack;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t expq[$];

    sysbus_port_arbiter dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_reqtag(i_reqtag), .i_reqdata(i_reqdata), .i_reqcyc(i_reqcyc),
        .i_reqack(i_reqack), .i_resp(i_resp), .i_resptag(i_resptag), .i_respcyc(i_respcyc),
        .i_writeack(i_writeack),
        .d_req(d_req), .d_reqtag(d_reqtag), .d_reqdata(d_reqdata), .d_reqcyc(d_reqcyc),
        .d_reqack(d_reqack), .d_resp(d_resp), .d_resptag(d_resptag), .d_respcyc(d_respcyc),
        .d_writeack(d_writeack),
        .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqdata(bus_reqdata),
        .bus_reqcyc(bus_reqcyc), .bus_reqack(bus_reqack), .bus_resp(bus_resp),
        .bus_resptag(bus_resptag), .bus_respcyc(bus_respcyc), .bus_respack(bus_respack),
        .bus_writeack(bus_writeack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input int side, input logic [63:0] data,
                        input logic [12:0] tag, input int at);
        exp_t e;
        e.kind = kind; e.side = side; e.data = data; e.tag = tag; e.cyc = at;
        expq.push_back(e);
    endtask

    task automatic mon(input int kind, input int side, input logic [63:0] data,
                       input logic [12:0] tag);
        exp_t e;
        checks++;
        if (expq.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event kind=%0d side=%0d cyc=%0d", kind, side, cyc);
        end else begin
            e = expq.pop_front();
            if (e.kind != kind || e.side != side || (e.cyc >= 0 && e.cyc != cyc) ||
                (kind == KIND_BEAT && (e.data !== data || e.tag !== tag || bus_respack !== 1'b1))) begin
                failures++;
                $display("FAIL event actual kind=%0d side=%0d data=%h tag=%h cyc=%0d respack=%b expected kind=%0d side=%0d data=%h tag=%h cyc=%0d",
                         kind, side, data, tag, cyc, bus_respack, e.kind, e.side, e.data, e.tag, e.cyc);
            end
        end
    endtask

    // Monitor: every requester-facing strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (i_reqack)   mon(KIND_ACK, 0, 64'h0, 13'h0);
            if (d_reqack)   mon(KIND_ACK, 1, 64'h0, 13'h0);
            if (i_respcyc)  mon(KIND_BEAT, 0, i_resp, i_resptag);
            if (d_respcyc)  mon(KIND_BEAT, 1, d_resp, d_resptag);
            if (i_writeack) mon(KIND_WACK, 0, 64'h0, 13'h0);
            if (d_writeack) mon(KIND_WACK, 1, 64'h0, 13'h0);
        end
    end

    // Requesters drop reqcyc once they see their grant pulse.
    always @(negedge clk) begin
        if (i_reqack) i_reqcyc = 1'b0;
        if (d_reqack) d_reqcyc = 1'b0;
    end

    task automatic do_issue(input string name, input logic [63:0] addr, input logic [12:0] tag,
                            input logic [63:0] data, input int stall, input bit raise_d,
                            output int lat);
        int n = 0;
        while (!bus_reqcyc && n < 40) begin
            @(negedge clk);
            n++;
        end
        lat = n;
        chk({name, "_reqcyc"}, {63'h0, bus_reqcyc}, 64'h1);
        chk({name, "_addr"}, bus_req, addr);
        chk({name, "_tag"}, {51'h0, bus_reqtag}, {51'h0, tag});
        chk({name, "_data"}, bus_reqdata, data);
        if (raise_d) begin
            d_req = 64'h480; d_reqtag = 13'h1011; d_reqdata = 64'hBEEF; d_reqcyc = 1'b1;
        end
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk({name, "_stall_hold"}, {bus_reqcyc, bus_reqtag, bus_req[49:0]}, {1'b1, tag, addr[49:0]});
        end
        bus_reqack = 1'b1;
        @(negedge clk);
        bus_reqack = 1'b0;
        chk({name, "_release"}, {63'h0, bus_reqcyc}, 64'h0);
    endtask

    task automatic read_beats(input int side, input logic [12:0] tag, input logic [63:0] base,
                              input int gaps[8], input int nb);
        for (int k = 0; k < nb; k++) begin
            bus_respcyc = 1'b0;
            repeat (gaps[k]) @(negedge clk);
            bus_resp = base + 64'(k); bus_resptag = tag; bus_respcyc = 1'b1;
            push(KIND_BEAT, side, base + 64'(k), tag, cyc + 1);
            @(negedge clk);
        end
        bus_respcyc = 1'b0;
    endtask

    task automatic write_resp(input int side, input bit stray);
        if (stray) begin
            bus_resp = 64'hBAD; bus_resptag = 13'h7; bus_respcyc = 1'b1;
            @(negedge clk);
            bus_respcyc = 1'b0;
            chk("stray_beat_acked", {63'h0, bus_respack}, 64'h1);
        end
        bus_writeack = 1'b1;
        push(KIND_WACK, side, 64'h0, 13'h0, cyc + 1);
        @(negedge clk);
        bus_writeack = 1'b0;
    endtask

    task automatic outputs_zero(input string name);
        chk({name, "_strobes"}, {56'h0, i_reqack, d_reqack, i_respcyc, d_respcyc,
                                 i_writeack, d_writeack, bus_reqcyc, bus_respack}, 64'h0);
        chk({name, "_bus_payload"}, bus_req | bus_reqdata | {51'h0, bus_reqtag}, 64'h0);
        chk({name, "_resp_payload"}, i_resp | d_resp | {51'h0, i_resptag | d_resptag}, 64'h0);
    endtask

    int g0[8];
    int gg[8];
    int lat;

    initial begin
        g0 = '{0, 0, 0, 0, 0, 0, 0, 0};
        gg = '{0, 2, 0, 4, 1, 0, 0, 3};
        reset = 1'b1;
        {i_req, i_reqtag, i_reqdata, i_reqcyc} = '0;
        {d_req, d_reqtag, d_reqdata, d_reqcyc} = '0;
        {bus_reqack, bus_resp, bus_resptag, bus_respcyc, bus_writeack} = '0;
        repeat (3) @(negedge clk);
        outputs_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // Tie straight after reset: I first, D after I's last beat plus one IDLE cycle.
        i_req = 64'h100; i_reqtag = 13'h0040; i_reqdata = 64'h0; i_reqcyc = 1'b1;
        d_req = 64'h2000; d_reqtag = 13'h1010; d_reqdata = 64'hDEAD; d_reqcyc = 1'b1;
        push(KIND_ACK, 0, 64'h0, 13'h0, cyc + 1);
        do_issue("i_read", 64'h100, 13'h0040, 64'h0, 0, 1'b0, lat);
        chk("req_to_bus_latency", 64'(lat), 64'd1);
        read_beats(0, 13'h0040, 64'h1, g0, 8);
        push(KIND_ACK, 1, 64'h0, 13'h0, cyc + 1);
        do_issue("d_write", 64'h2000, 13'h1010, 64'hDEAD, 0, 1'b0, lat);
        write_resp(1, 1'b1);

        // I read alone with gaps between beats.
        @(negedge clk);
        i_req = 64'h140; i_reqtag = 13'h0041; i_reqcyc = 1'b1;
        push(KIND_ACK, 0, 64'h0, 13'h0, cyc + 1);
        do_issue("i_gap_read", 64'h140, 13'h0041, 64'h0, 0, 1'b0, lat);
        read_beats(0, 13'h0041, 64'h10, gg, 8);

        // Tie after an I grant goes to D; pending I follows with a stalled bus_reqack.
        @(negedge clk);
        i_req = 64'h180; i_reqtag = 13'h0042; i_reqcyc = 1'b1;
        d_req = 64'h400; d_reqtag = 13'h0013; d_reqdata = 64'h0; d_reqcyc = 1'b1;
        push(KIND_ACK, 1, 64'h0, 13'h0, cyc + 1);
        do_issue("d_read", 64'h400, 13'h0013, 64'h0, 0, 1'b0, lat);
        read_beats(1, 13'h0013, 64'h20, g0, 8);
        push(KIND_ACK, 0, 64'h0, 13'h0, cyc + 1);
        do_issue("i_stall", 64'h180, 13'h0042, 64'h0, 5, 1'b1, lat);
        read_beats(0, 13'h0042, 64'h30, g0, 8);
        push(KIND_ACK, 1, 64'h0, 13'h0, cyc + 1);
        do_issue("d_write2", 64'h480, 13'h1011, 64'hBEEF, 0, 1'b0, lat);
        write_resp(1, 1'b0);

        // Reset in WAIT after 3 beats, then a fresh tie must favour I and need 8 beats.
        @(negedge clk);
        i_req = 64'h500; i_reqtag = 13'h0044; i_reqcyc = 1'b1;
        push(KIND_ACK, 0, 64'h0, 13'h0, cyc + 1);
        do_issue("i_abort", 64'h500, 13'h0044, 64'h0, 0, 1'b0, lat);
        read_beats(0, 13'h0044, 64'h40, g0, 3);
        #2 reset = 1'b1;
        #1 outputs_zero("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        i_req = 64'h600; i_reqtag = 13'h0045; i_reqcyc = 1'b1;
        d_req = 64'h700; d_reqtag = 13'h1012; d_reqdata = 64'h55; d_reqcyc = 1'b1;
        push(KIND_ACK, 0, 64'h0, 13'h0, cyc + 1);
        do_issue("i_fresh", 64'h600, 13'h0045, 64'h0, 0, 1'b0, lat);
        read_beats(0, 13'h0045, 64'h50, g0, 8);
        push(KIND_ACK, 1, 64'h0, 13'h0, cyc + 1);
        do_issue("d_write3", 64'h700, 13'h1012, 64'h55, 0, 1'b0, lat);
        write_resp(1, 1'b0);

        repeat (4) @(negedge clk);
        chk("cleanup_strobes", {58'h0, i_respcyc, d_respcyc, i_writeack, d_writeack,
                                bus_respack, bus_reqcyc}, 64'h0);
        chk("scoreboard_empty", 64'(expq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sysbus_port_arbiter.md
Name: sysbus_port_arbiter

Overview:
- Shares the single SysBus memory port between the instruction-fetch requester (I side) and the data requester (D side).
- The D side is the read/writeback arbiter output of the data cache.
- Serialises one bus transaction at a time and uses 2-way round-robin when both sides request in the same cycle.
- Routes multi-beat read data or the write acknowledge back to the owning requester.

Parameters:
- WIDTH, 64, bus data width in bits.
- TAG_WIDTH, 13, request/response tag width; bit TAG_WIDTH-1 set marks a write.
- BEATS, 8, response beats per read transaction (cache line = BEATS*WIDTH bits).

Ports:
- clk  in  1  clock, all state on posedge.
- reset  in  1  asynchronous, active-high reset.
- {i,d}_req  in  WIDTH  request address.
- {i,d}_reqtag  in  TAG_WIDTH  request tag.
- {i,d}_reqdata  in  WIDTH  write data (D side only meaningful).
- {i,d}_reqcyc  in  1  request valid; held until reqack seen.
- {i,d}_reqack  out  1  one-cycle grant pulse.
- {i,d}_resp  out  WIDTH  forwarded read beat.
- {i,d}_resptag  out  TAG_WIDTH  forwarded response tag.
- {i,d}_respcyc  out  1  beat valid; requester must consume the beat that cycle.
- {i,d}_writeack  out  1  one-cycle write-complete pulse.
- bus_req  out  WIDTH  to SysBus.
- bus_reqtag  out  TAG_WIDTH  to SysBus.
- bus_reqdata  out  WIDTH  to SysBus.
- bus_reqcyc  out  1  to SysBus.
- bus_reqack  in  1  SysBus accepted request.
- bus_resp  in  WIDTH  SysBus read beat.
- bus_resptag  in  TAG_WIDTH  SysBus response tag.
- bus_respcyc  in  1  beat valid.
- bus_respack  out  1  beat acknowledge to SysBus.
- bus_writeack  in  1  write complete.

Behaviour:
- Reset values:
  - All outputs are 0 and state is IDLE.
  - owner = NONE; last_grant = D, so I wins the first tie.
  - beat_cnt = 0.
- All outputs are registered. There is no combinational path from any input to any output.
- IDLE:
  - Sample {i,d}_reqcyc.
  - If only one side requests, it wins. If both request, the side not equal to last_grant wins.
  - On a grant at edge N:
    - bus_req, bus_reqtag and bus_reqdata capture the winner's values.
    - bus_reqcyc = 1 and winner reqack = 1.
    - owner = winner; last_grant = winner.
    - is_write = reqtag[TAG_WIDTH-1]; beat_cnt = 0.
    - Go to ISSUE.
  - If neither side requests, stay in IDLE.
- ISSUE:
  - reqack returns to 0 at the next edge (one-cycle pulse).
  - Hold bus_reqcyc and the bus payload stable until bus_reqack is sampled 1.
  - Then bus_reqcyc = 0 and go to WAIT.
- WAIT, read (is_write = 0):
  - Each edge where bus_respcyc = 1: owner resp/resptag = bus values, owner respcyc = 1, bus_respack = 1, beat_cnt += 1.
  - Each edge without a beat: respcyc = 0 and bus_respack = 0.
  - When the beat with beat_cnt == BEATS-1 is sampled, forward it and go to IDLE.
  - Forwarding latency is 1 cycle per beat. Gaps between beats are allowed.
- WAIT, write (is_write = 1):
  - bus_writeack sampled 1 -> owner writeack = 1 for one cycle, go to IDLE.
  - Any bus_respcyc in this state is acked and dropped, never forwarded.
- Non-owner: reqack, respcyc and writeack stay 0 for the entire transaction. Its reqcyc is ignored outside IDLE.
- Cleanup: the cycle after entering IDLE, all respcyc, writeack and bus_respack are 0.
- Minimum spacing: one IDLE cycle separates transactions. Request-to-bus latency is 1 cycle.
- An I-side request with the write bit set is forwarded unchanged as a write. An assertion flags it.
- A bus_reqack seen outside ISSUE is ignored.
- Reset mid-transaction: immediate return to reset values. bus_reqcyc drops asynchronously and any in-flight transaction is abandoned. SysBus must be reset together with this block.
- beat_cnt is $clog2(BEATS) bits and is never compared past BEATS-1.

Decomposition:
- Package sysbus_arb_pkg holds:
  - the state enum {IDLE, ISSUE, WAIT};
  - the owner enum {NONE, ISIDE, DSIDE};
  - the constant WRITE_TAG_BIT = TAG_WIDTH-1.
- One sub-module, rr_picker2: 2-way round-robin select with last_grant register and a grant-enable input.
- The FSM and payload registers stay in the top module.

Test Plan:
- I read alone, tag 0x0040: bus_reqcyc rises 1 cycle after i_reqcyc. Release on bus_reqack. 8 beats 0x1..0x8 appear on i_resp 1 cycle each later with i_respcyc. d_respcyc stays 0. Back to IDLE.
- I and D both assert in the same cycle after reset: I granted first (i_reqack pulse). D granted after I's 8th beat plus 1 IDLE cycle. Next tie goes to D.
- D write, tag 0x1000|0x10, data 0xDEAD: bus_reqdata = 0xDEAD. bus_writeack -> d_writeack single-cycle pulse. i_writeack stays 0.
- Read with beat gaps: beats arrive at cycles 0, 3, 4, 9, ... Each is forwarded exactly 1 cycle later. Completion only after the 8th beat.
- Reset asserted during WAIT after 3 beats: all outputs 0 immediately. The next request starts fresh with beat_cnt = 0 and I priority.
- bus_reqack held low for 5 cycles: bus_reqcyc and payload stay stable, and no other grant occurs.
